// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer between pc_adder, instruction memory and decode.
// It runs the boot delay, issues imem reads, loads the IF/ID register, and handles redirects and stalls.
module pc_fetch_ctrl #(
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
  parameter int          BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        trap_req,
  input  logic        id_stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        pc_stop,
  output logic        jump_start,
  output logic [31:0] pc_jump,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [15:0] BOOT_INIT = 16'(BOOT_DELAY);

  logic [1:0]  state_r;
  logic [15:0] cnt_r;
  logic [31:0] hold_r;
  logic        redir_s;
  logic        free_s;
  logic        outstanding_s;

  // Redirects are ignored while booting; trap outranks branch.
  assign redir_s       = (state_r != ST_BOOT) && (trap_req || br_taken);
  assign free_s        = !if_valid || !id_stall;
  assign outstanding_s = (state_r == ST_REQ) || (state_r == ST_DROP);
  assign imem_addr     = pc_in;

  // pc_adder control and the imem request strobe
  always_comb begin
    pc_stop    = 1'b1;
    jump_start = 1'b0;
    pc_jump    = 32'd0;
    imem_req   = (state_r == ST_REQ);
    if (redir_s) begin
      pc_stop    = 1'b0;
      jump_start = 1'b1;
      if (trap_req) begin
        pc_jump = TRAP_VEC - pc_in;
      end else begin
        pc_jump = br_offset;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (imem_ready && free_s) begin
            pc_stop = 1'b0;
          end else begin
            pc_stop = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            pc_stop = 1'b0;
          end else begin
            pc_stop = 1'b1;
          end
        end
        default: pc_stop = 1'b1;
      endcase
    end
  end

  // Sequencer state, boot counter, hold buffer and the IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_BOOT;
      cnt_r    <= BOOT_INIT;
      hold_r   <= 32'd0;
      if_valid <= 1'b0;
      if_instr <= 32'd0;
      if_pc    <= 32'd0;
    end else if (redir_s) begin
      // Any data returning with the redirect is discarded.
      if_valid <= 1'b0;
      hold_r   <= 32'd0;
      if (outstanding_s && !imem_ready) begin
        state_r <= ST_DROP;
      end else begin
        state_r <= ST_REQ;
      end
    end else begin
      case (state_r)
        ST_BOOT: begin
          cnt_r <= cnt_r - 16'd1;
          if (cnt_r <= 16'd1) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_BOOT;
          end
        end
        ST_REQ: begin
          if (imem_ready && free_s) begin
            if_instr <= imem_rdata;
            if_pc    <= pc_in;
            if_valid <= 1'b1;
          end else if (imem_ready) begin
            hold_r  <= imem_rdata;
            state_r <= ST_HOLD;
          end else if (!id_stall) begin
            if_valid <= 1'b0;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_HOLD: begin
          if (!id_stall) begin
            if_instr <= hold_r;
            if_pc    <= pc_in;
            if_valid <= 1'b1;
            state_r  <= ST_REQ;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_ready) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: state_r <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural pc_adder and imem.
// Outputs are sampled on the falling edge and inputs change there.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = 32'd0;
  logic        trap_req = 1'b0;
  logic        id_stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic        force_data = 1'b0;
  logic [31:0] fixed_data = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        pc_stop;
  logic        jump_start;
  logic [31:0] pc_jump;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.TRAP_VEC(32'h0000_0100), .BOOT_DELAY(2)) dut (
    .clk(clk), .reset(reset), .pc_in(pc), .br_taken(br_taken),
    .br_offset(br_offset), .trap_req(trap_req), .id_stall(id_stall),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_stop(pc_stop), .jump_start(jump_start),
    .pc_jump(pc_jump), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );

  // Behavioural pc_adder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= 32'd0;
    else if (!pc_stop) pc <= pc + (jump_start ? pc_jump : 32'd4);
  end

  // Memory image: a tag word in the upper half and the address in the lower half.
  assign imem_rdata = force_data ? fixed_data : {16'hC0DE, imem_addr[15:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset and boot
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_stop", {31'd0, pc_stop}, 32'd1);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1 chk("boot_c1_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("boot_c2_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("boot_c3_req", {31'd0, imem_req}, 32'd1);
    chk("boot_c3_addr", imem_addr, 32'h0);
    tick();
    chk("seq_valid", {31'd0, if_valid}, 32'd1);
    chk("seq_pc0", if_pc, 32'h0);
    chk("seq_instr0", if_instr, 32'hC0DE_0000);
    tick();
    chk("seq_pc4", if_pc, 32'h4);
    tick();
    chk("seq_pc8", if_pc, 32'h8);
    chk("seq_addr", imem_addr, 32'hC);

    // Branch to 0x40 to set up the backward branch
    br_taken = 1'b1; br_offset = 32'h34;
    #1 chk("br1_jump", pc_jump, 32'h34);
    chk("br1_stop", {31'd0, pc_stop}, 32'd0);
    tick();
    br_taken = 1'b0;
    chk("br1_valid", {31'd0, if_valid}, 32'd0);
    chk("br1_addr", imem_addr, 32'h40);

    // Backward branch with a negative offset
    br_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
    #1 chk("br2_js", {31'd0, jump_start}, 32'd1);
    chk("br2_jump", pc_jump, 32'hFFFF_FFF0);
    tick();
    br_taken = 1'b0;
    chk("br2_valid", {31'd0, if_valid}, 32'd0);
    chk("br2_addr", imem_addr, 32'h30);
    tick();
    chk("br2_ifpc", if_pc, 32'h30);
    chk("br2_instr", if_instr, 32'hC0DE_0030);

    // Trap outranks a simultaneous branch
    br_taken = 1'b1; br_offset = 32'h1CC;
    tick();
    br_taken = 1'b0;
    chk("tr_pre_addr", imem_addr, 32'h200);
    trap_req = 1'b1; br_taken = 1'b1; br_offset = 32'h1234;
    #1 chk("tr_jump", pc_jump, 32'hFFFF_FF00);
    chk("tr_js", {31'd0, jump_start}, 32'd1);
    tick();
    trap_req = 1'b0; br_taken = 1'b0;
    chk("tr_addr", imem_addr, 32'h100);
    chk("tr_valid", {31'd0, if_valid}, 32'd0);

    // Stall with data returning: park the word in HOLD
    tick();
    chk("hd_pre_pc", if_pc, 32'h100);
    id_stall = 1'b1; force_data = 1'b1; fixed_data = 32'h0000_DEAD;
    #1 chk("hd_stop", {31'd0, pc_stop}, 32'd1);
    tick();
    chk("hd_req", {31'd0, imem_req}, 32'd0);
    chk("hd_frozen", imem_addr, 32'h104);
    chk("hd_ifpc", if_pc, 32'h100);
    force_data = 1'b0;
    tick();
    chk("hd_frozen2", imem_addr, 32'h104);
    chk("hd_instr_keep", if_instr, 32'hC0DE_0100);
    id_stall = 1'b0;
    #1 chk("hd_rel_stop", {31'd0, pc_stop}, 32'd0);
    tick();
    chk("hd_instr", if_instr, 32'h0000_DEAD);
    chk("hd_ifpc2", if_pc, 32'h104);
    chk("hd_addr", imem_addr, 32'h108);

    // Redirect while a request is outstanding, then again while in DROP
    imem_ready = 1'b0;
    tick();
    chk("dr_valid_clr", {31'd0, if_valid}, 32'd0);
    chk("dr_req_wait", {31'd0, imem_req}, 32'd1);
    br_taken = 1'b1; br_offset = 32'h100;
    tick();
    chk("dr_req0", {31'd0, imem_req}, 32'd0);
    chk("dr_addr1", imem_addr, 32'h208);
    br_offset = 32'h10;
    tick();
    br_taken = 1'b0;
    chk("dr_req1", {31'd0, imem_req}, 32'd0);
    chk("dr_addr2", imem_addr, 32'h218);
    imem_ready = 1'b1; force_data = 1'b1; fixed_data = 32'hBAD0_BAD0;
    tick();
    force_data = 1'b0;
    chk("dr_discard", {31'd0, if_valid}, 32'd0);
    chk("dr_resume", {31'd0, imem_req}, 32'd1);
    chk("dr_addr3", imem_addr, 32'h218);
    tick();
    chk("dr_ifpc", if_pc, 32'h218);
    chk("dr_instr", if_instr, 32'hC0DE_0218);

    // Asynchronous reset while in HOLD
    id_stall = 1'b1;
    tick();
    chk("ar_hold", {31'd0, imem_req}, 32'd0);
    chk("ar_addr", imem_addr, 32'h21C);
    #2 reset = 1'b1;
    #1 chk("ar_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_instr", if_instr, 32'd0);
    chk("ar_ifpc", if_pc, 32'd0);
    chk("ar_stop", {31'd0, pc_stop}, 32'd1);
    chk("ar_js", {31'd0, jump_start}, 32'd0);
    chk("ar_jump", pc_jump, 32'd0);
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0; id_stall = 1'b0; br_taken = 1'b1; br_offset = 32'h40;
    #1 chk("bt_ign_js", {31'd0, jump_start}, 32'd0);
    chk("bt_ign_stop", {31'd0, pc_stop}, 32'd1);
    tick();
    chk("bt_c2_req", {31'd0, imem_req}, 32'd0);
    chk("bt_c2_addr", imem_addr, 32'd0);
    br_taken = 1'b0;
    tick();
    chk("bt_c3_req", {31'd0, imem_req}, 32'd1);
    chk("bt_c3_addr", imem_addr, 32'd0);
    tick();
    chk("bt_ifpc", if_pc, 32'd0);
    chk("bt_valid", {31'd0, if_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
